// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: walks an active-low column strobe on each clken tick, debounces
// whole-frame results and emits one code per press. Define KEYPAD_ENTRY_EN for the 16-bit entry register.
module keypad_scanner #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  input  logic        clr,
  output logic [15:0] value
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: code_of = 4'h1;  4'h1: code_of = 4'h2;  4'h2: code_of = 4'h3;  4'h3: code_of = 4'hA;
      4'h4: code_of = 4'h4;  4'h5: code_of = 4'h5;  4'h6: code_of = 4'h6;  4'h7: code_of = 4'hB;
      4'h8: code_of = 4'h7;  4'h9: code_of = 4'h8;  4'hA: code_of = 4'h9;  4'hB: code_of = 4'hC;
      4'hC: code_of = 4'h0;  4'hD: code_of = 4'hF;  4'hE: code_of = 4'hE;  default: code_of = 4'hD;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [3:0] col_q, col_d;
  logic [1:0] acc_n_q, acc_n_d;       // pressed bits so far this frame, saturating at 2 (MULTI)
  logic [3:0] acc_code_q, acc_code_d;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;

  logic [3:0] pressed;
  logic [2:0] col_n, sum_n;
  logic [1:0] ridx, tot_n;
  logic [3:0] tot_code;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    sync_d      = {sync_q[SYNC_STAGES-2:0], row};
    col_idx_d   = col_idx_q;
    col_d       = col_q;
    acc_n_d     = acc_n_q;
    acc_code_d  = acc_code_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    pressed = ~sync_q[SYNC_STAGES-1];
    col_n   = 3'd0;
    ridx    = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (pressed[r]) begin
        col_n = col_n + 3'd1;
        ridx  = 2'(r);
      end
    end
    sum_n    = {1'b0, acc_n_q} + col_n;
    tot_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    tot_code = (acc_n_q != 2'd0) ? acc_code_q : code_of(ridx, col_idx_q);

    if (clken) begin
      col_idx_d = col_idx_q + 2'd1;
      col_d     = ~(4'b0001 << col_idx_d);
      if (col_idx_q != 2'd3) begin
        acc_n_d    = tot_n;
        acc_code_d = tot_code;
      end else begin
        acc_n_d    = 2'd0;
        acc_code_d = 4'h0;
        case (state_q)
          IDLE: if (tot_n == 2'd1) begin
            cand_d = tot_code;
            cnt_d  = 4'd1;
            if (DEB == 4'd1) begin
              state_d     = PRESSED;
              key_code_d  = tot_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end
          DEBOUNCE: if (tot_n == 2'd1 && tot_code == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == DEB) begin
              state_d     = PRESSED;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
          PRESSED: if (tot_n == 2'd0) begin
            cnt_d = 4'd1;
            if (DEB == 4'd1) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end else begin
              state_d = RELEASE;
            end
          end
          RELEASE: if (tot_n == 2'd0) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == DEB) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end
          end else begin
            state_d = PRESSED;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state is only ever updated with non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '1;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      acc_n_q     <= 2'd0;
      acc_code_q  <= 4'h0;
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      acc_n_q     <= acc_n_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

`ifdef KEYPAD_ENTRY_EN
  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr)              value_d = 16'h0000;
    else if (key_valid_q) value_d = {value_q[11:0], key_code_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value_q <= 16'h0000;
    else      value_q <= value_d;
  end

  assign value = value_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign value      = 16'h0000;
`endif

endmodule
